// File: rtl/shift_seq.sv
// shift_seq: multi-cycle barrel shifter (sll/sra) applying one power-of-two stage per cycle.
module shift_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic        op,
  input  logic [31:0] data_in,
  input  logic [4:0]  shamt,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, next;
  logic [31:0] work, staged;
  logic [4:0]  amt, k;
  logic [2:0]  cnt;
  logic        wop, accept;
  assign accept = state == IDLE && start && !kill;
  // cnt walks 4..0, so this stage shifts by 16, 8, 4, 2, 1 in turn
  assign k      = 5'd1 << cnt;
  assign staged = !amt[cnt] ? work : wop ? 32'($signed(work) >>> k) : work << k;
  always_ff @(posedge clock)
    state <= !reset ? IDLE : next;
  always_comb begin
    next = state == IDLE  ? (accept ? SHIFT : IDLE) :
           state == SHIFT ? (kill ? IDLE : cnt == 3'd0 ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    ready = state == IDLE;
    busy  = state == SHIFT;
    done  = state == DONE;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      work     <= '0;
      amt      <= '0;
      wop      <= 1'b0;
      cnt      <= '0;
      data_out <= '0;
    end else if (accept) begin
      work <= data_in;
      amt  <= shamt;
      wop  <= op;
      cnt  <= 3'd4;
    end else if (state == SHIFT && !kill) begin
      work <= staged;
      cnt  <= cnt - 3'd1;
      if (cnt == 3'd0) data_out <= staged;
    end
  end
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: randomized and directed checks of shift_seq against a plain shift model.
module tb_shift_seq;
  logic        clock = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0, op = 1'b0;
  logic [31:0] data_in = '0, data_out;
  logic [4:0]  shamt = '0;
  logic        ready, busy, done;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] last_out = '0;

  shift_seq dut (
    .clock(clock), .reset(reset), .start(start), .kill(kill), .op(op),
    .data_in(data_in), .shamt(shamt), .data_out(data_out),
    .ready(ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_shift(input logic o, input logic [31:0] d, input logic [4:0] s);
    return o ? 32'($signed(d) >>> s) : d << s;
  endfunction

  // Issue one operation at a negedge, scramble operands afterwards, wait for done.
  task automatic run_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                        output int lat, output logic [31:0] res);
    op = o; data_in = d; shamt = s; start = 1'b1; lat = 0;
    @(negedge clock);
    start = 1'b0; op = 1'($urandom); data_in = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      n_cmp++;
      if (data_out !== last_out) begin
        n_err++;
        $display("FAIL hold_during_shift: data_out=%h required %h", data_out, last_out);
      end
      @(negedge clock);
      lat++;
    end
    res = data_out;
    @(negedge clock);
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL return_idle: ready=%b done=%b required ready=1 done=0", ready, done);
    end
  endtask

  task automatic check_op(input string name, input logic o, input logic [31:0] d, input logic [4:0] s);
    int lat;
    logic [31:0] res, exp;
    exp = ref_shift(o, d, s);
    run_op(o, d, s, lat, res);
    n_cmp++;
    if (res !== exp) begin
      n_err++;
      $display("FAIL %s: op=%b d=%h s=%0d data_out=%h required %h", name, o, d, s, res, exp);
    end
    n_cmp++;
    if (lat !== 6) begin
      n_err++;
      $display("FAIL %s_latency: op=%b s=%0d latency=%0d required 6", name, o, s, lat);
    end
    last_out = exp;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; kill = 1'b0; op = 1'b1; data_in = 32'hDEADBEEF; shamt = 5'd3;
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) begin
        n_err++;
        $display("FAIL reset_state: ready=%b busy=%b done=%b data_out=%h required 1 0 0 00000000",
                 ready, busy, done, data_out);
      end
    end
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    last_out = '0;
    // first edge with reset released must accept
    check_op("first_after_reset", 1'b0, 32'h0000_00FF, 5'd4);
  endtask

  task automatic test_directed;
    check_op("sra_msb_4",   1'b1, 32'h8000_0000, 5'd4);
    check_op("sll_1_31",    1'b0, 32'h0000_0001, 5'd31);
    check_op("sra_msb_31",  1'b1, 32'h8000_0000, 5'd31);
    check_op("sra_pos_8",   1'b1, 32'h7FFF_FF00, 5'd8);
    check_op("sra_zero",    1'b1, 32'hA5A5_A5A5, 5'd0);
    check_op("sll_zero",    1'b0, 32'h5A5A_5A5A, 5'd0);
    n_cmp++;
    if (data_out !== 32'h5A5A_5A5A) begin
      n_err++;
      $display("FAIL idle_hold: data_out=%h required 5a5a5a5a", data_out);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      check_op("random", 1'($urandom), $urandom, 5'($urandom));
  endtask

  task automatic test_back_to_back;
    int ndone = 0;
    logic [31:0] exp = ref_shift(1'b1, 32'hF000_1234, 5'd5);
    op = 1'b1; data_in = 32'hF000_1234; shamt = 5'd5; start = 1'b1;
    @(negedge clock);
    op = 1'b0; data_in = 32'h0000_0003; shamt = 5'd1;
    for (int c = 1; c < 14; c++) begin
      if (c == 4) start = 1'b0;
      if (done) begin
        ndone++;
        n_cmp++;
        if (data_out !== exp) begin
          n_err++;
          $display("FAIL ignore_start_result: data_out=%h required %h", data_out, exp);
        end
      end
      @(negedge clock);
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL ignore_start_done_count: done pulses=%0d required 1", ndone);
    end
    last_out = exp;
  endtask

  task automatic test_kill;
    int ndone = 0;
    op = 1'b0; data_in = 32'h1234_5678; shamt = 5'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || data_out !== last_out) begin
      n_err++;
      $display("FAIL kill_shift: ready=%b busy=%b data_out=%h required 1 0 %h",
               ready, busy, data_out, last_out);
    end
    repeat (10) begin
      if (done) ndone++;
      @(negedge clock);
    end
    n_cmp++;
    if (ndone !== 0 || data_out !== last_out) begin
      n_err++;
      $display("FAIL kill_no_done: done pulses=%0d data_out=%h required 0 %h", ndone, data_out, last_out);
    end
    start = 1'b1; kill = 1'b1;
    @(negedge clock);
    start = 1'b0; kill = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL kill_priority: ready=%b busy=%b required 1 0", ready, busy);
    end
  endtask

  task automatic test_kill_in_done;
    int lat = 1;
    logic [31:0] exp = ref_shift(1'b1, 32'h8765_4321, 5'd13);
    op = 1'b1; data_in = 32'h8765_4321; shamt = 5'd13; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    kill = 1'b1;
    n_cmp++;
    if (done !== 1'b1 || data_out !== exp) begin
      n_err++;
      $display("FAIL kill_in_done: done=%b data_out=%h required 1 %h", done, data_out, exp);
    end
    @(negedge clock);
    kill = 1'b0;
    n_cmp++;
    if (ready !== 1'b1 || done !== 1'b0 || data_out !== exp) begin
      n_err++;
      $display("FAIL kill_in_done_idle: ready=%b done=%b data_out=%h required 1 0 %h",
               ready, done, data_out, exp);
    end
    last_out = exp;
  endtask

  task automatic test_reset_mid;
    int ndone = 0;
    op = 1'b0; data_in = 32'hCAFE_F00D; shamt = 5'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid: ready=%b busy=%b done=%b data_out=%h required 1 0 0 00000000",
               ready, busy, done, data_out);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (8) begin
      if (done) ndone++;
      @(negedge clock);
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_err++;
      $display("FAIL reset_mid_no_done: done pulses=%0d required 0", ndone);
    end
    last_out = '0;
    check_op("after_reset_mid", 1'b1, 32'h8000_0010, 5'd3);
  endtask

  initial begin
    @(negedge clock);
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_kill;
    test_kill_in_done;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; no other clock or asynchronous input SHALL exist.
REQ-002 Port `clock`, input, 1 bit: rising-edge system clock.
REQ-003 Port `reset`, input, 1 bit: synchronous active-low reset, sampled only on a rising `clock` edge.
REQ-004 Port `start`, input, 1 bit: request a shift; sampled on each rising edge.
REQ-005 Port `kill`, input, 1 bit: abort any in-flight operation.
REQ-006 Port `op`, input, 1 bit: 0 = logical left shift (sll), 1 = arithmetic right shift (sra).
REQ-007 Port `data_in`, input, 32 bits: operand, captured on accepted `start`.
REQ-008 Port `shamt`, input, 5 bits: shift amount 0..31, captured on accepted `start`.
REQ-009 Port `data_out`, output, 32 bits: result register.
REQ-010 Port `ready`, output, 1 bit: high only in IDLE; `start` is accepted only when high.
REQ-011 Port `busy`, output, 1 bit: high in SHIFT.
REQ-012 Port `done`, output, 1 bit: single-cycle pulse, high only in DONE.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with `ready`/`busy`/`done` decoded one-hot from the state.
REQ-014 In IDLE with `start`=1 and `kill`=0, the edge SHALL latch `op`, `data_in` and `shamt` into internal working registers, set stage counter `cnt`=4, and enter SHIFT.
REQ-015 In IDLE with `start`=0, the state and all registers SHALL hold.
REQ-016 Each SHIFT edge SHALL apply stage 2^`cnt` to the working value when `shamt`[`cnt`]=1, and pass it through unchanged otherwise.
REQ-017 In the same SHIFT edge, `cnt` SHALL decrement.
REQ-018 Stage order SHALL be 16, 8, 4, 2, 1: one stage per cycle, and exactly 5 SHIFT cycles regardless of `shamt`, including `shamt`=0.
REQ-019 An sra stage of k SHALL fill the upper k bits with bit 31 of the current working value.
REQ-020 An sll stage of k SHALL fill the lower k bits with 0.
REQ-021 Bits shifted out SHALL be discarded, and no wrap-around SHALL occur.
REQ-022 On the SHIFT edge where `cnt`=0, the final value SHALL be written to `data_out` and the FSM SHALL enter DONE.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-024 Latency SHALL be fixed: with `start` accepted at edge E0, `done`=1 during the cycle following edge E5, and `ready`=1 again after E6.
REQ-025 `data_out` SHALL change only at the DONE-entry edge and SHALL hold its value through IDLE until the next completion.
REQ-026 `start` SHALL be ignored while in SHIFT or DONE: no queuing, and no effect on captured operands.
REQ-027 Input changes on `data_in`, `shamt` and `op` after acceptance SHALL NOT affect the in-flight result.
REQ-028 `kill`=1 in SHIFT SHALL return the FSM to IDLE at the next edge; `data_out` SHALL be unchanged and no `done` pulse SHALL occur.
REQ-029 `kill`=1 in DONE SHALL NOT suppress the already-visible `done`; the FSM returns to IDLE as normal.
REQ-030 `kill` SHALL take priority over `start` in IDLE: with both high, the request is not accepted.

Reset
REQ-031 `reset`=0 at an edge SHALL force IDLE, `data_out`=0x00000000, `cnt`=0 and working registers to 0.
REQ-032 Under reset, outputs SHALL be `ready`=1, `busy`=0 and `done`=0.
REQ-033 Reset SHALL override `start` and `kill`, and an operation interrupted by reset SHALL produce no `done`.
REQ-034 The first `start` SHALL be accepted at the first edge with `reset`=1.

Verification
REQ-035 The bench SHALL cover: `op`=1, `data_in`=0x80000000, `shamt`=4 -> `done` 6 cycles after acceptance, `data_out`=0xF8000000.
REQ-036 The bench SHALL cover: `op`=0, `data_in`=0x00000001, `shamt`=31 -> `data_out`=0x80000000; `op`=1, `data_in`=0x80000000, `shamt`=31 -> `data_out`=0xFFFFFFFF.
REQ-037 The bench SHALL cover: `op`=1, `data_in`=0x7FFFFF00, `shamt`=8 -> `data_out`=0x007FFFFF; and `shamt`=0 -> `data_out`=`data_in`, with latency still 6.
REQ-038 The bench SHALL cover: `start` re-asserted during SHIFT with different operands -> ignored, with the first result and exactly one `done`.
REQ-039 The bench SHALL cover: `kill` pulsed in the 3rd SHIFT cycle -> IDLE next cycle, `data_out` retains its previous value, and no `done` occurs.
REQ-040 The bench SHALL cover: `reset`=0 mid-SHIFT -> next cycle `ready`=1 and `data_out`=0, then a new `start` completes correctly.
